// File: rtl/vga_scan_doubler.sv
// vga_scan_doubler: ping-pong line buffer that replays each 15 kHz input line twice at 2x pixel rate.
// Optional SCANLINES_EN: blank every second repeat while scanline_on is high.
module vga_scan_doubler #(
    parameter int COLOR_W = 4,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               nRESET,
    input  logic               ce_pix,
    input  logic               ce_pix2x,
    input  logic [COLOR_W-1:0] in_rgb,
    input  logic               in_hsync_n,
    input  logic               in_vsync_n,
    input  logic               scanline_on,
    output logic [COLOR_W-1:0] out_rgb,
    output logic               out_hsync_n,
    output logic               out_vsync_n,
    output logic               line_valid
);
    localparam logic [ADDR_W-1:0] MAX = {ADDR_W{1'b1}};

    logic [COLOR_W-1:0] mem [2**(ADDR_W+1)];
    logic [COLOR_W-1:0] rd_q;
    logic [ADDR_W-1:0]  hcnt_in_q, hcnt_in_d, hcnt_inc, line_len_q, hs_meas_q, hs_len_q;
    logic [ADDR_W-1:0]  hcnt_out_q, hcnt_out_d;
    logic               hs_prev_q, wr_bank_q, vs_latch_q, seen_q, line_valid_q, rep_q, rep_d;
    logic               blank_q, hs_out_q, vs_out_q, line_start, hs_rise, wrap, scan;

`ifdef SCANLINES_EN
    assign scan = scanline_on & rep_q;
`else
    logic unused_scanline;
    assign unused_scanline = scanline_on;
    assign scan = 1'b0;
`endif

    // hcnt_in is the index of the pixel just stored; the line-start sample is pixel 0
    always_comb begin
        line_start = ce_pix & hs_prev_q & ~in_hsync_n;
        hs_rise    = ce_pix & ~hs_prev_q & in_hsync_n;
        hcnt_inc   = (hcnt_in_q == MAX) ? MAX : hcnt_in_q + 1'b1;
        hcnt_in_d  = line_start ? '0 : hcnt_inc;
        wrap       = (line_len_q == '0) | (hcnt_out_q == line_len_q - 1'b1);
        hcnt_out_d = line_start ? '0 : !ce_pix2x ? hcnt_out_q : wrap ? '0 : hcnt_out_q + 1'b1;
        rep_d      = line_start ? 1'b0 : (ce_pix2x & wrap & (line_len_q != '0)) ? ~rep_q : rep_q;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            hs_prev_q    <= 1'b1;
            hcnt_in_q    <= '0;
            hs_meas_q    <= '0;
            line_len_q   <= '0;
            hs_len_q     <= '0;
            wr_bank_q    <= 1'b0;
            vs_latch_q   <= 1'b1;
            seen_q       <= 1'b0;
            line_valid_q <= 1'b0;
            hcnt_out_q   <= '0;
            rep_q        <= 1'b0;
            hs_out_q     <= 1'b1;
            vs_out_q     <= 1'b1;
            blank_q      <= 1'b1;
        end else begin
            hcnt_out_q <= hcnt_out_d;
            rep_q      <= rep_d;
            if (ce_pix) begin
                hs_prev_q <= in_hsync_n;
                hcnt_in_q <= hcnt_in_d;
                if (hs_rise)
                    hs_meas_q <= hcnt_inc;
                if (line_start) begin
                    line_len_q   <= hcnt_inc;
                    hs_len_q     <= hs_meas_q;
                    wr_bank_q    <= ~wr_bank_q;
                    vs_latch_q   <= in_vsync_n;
                    seen_q       <= 1'b1;
                    line_valid_q <= line_valid_q | seen_q;
                end
            end
            // sync and blank are registered alongside the RAM read so all outputs stay aligned
            if (ce_pix2x) begin
                hs_out_q <= ~(hcnt_out_q < hs_len_q);
                blank_q  <= (hcnt_out_q < hs_len_q) | ~line_valid_q | scan;
                if (hcnt_out_q == '0 && !rep_q)
                    vs_out_q <= vs_latch_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce_pix && hcnt_in_d != MAX)
            mem[{wr_bank_q ^ line_start, hcnt_in_d}] <= in_rgb;
        if (ce_pix2x)
            rd_q <= mem[{~wr_bank_q, hcnt_out_q}];
    end

    assign out_rgb     = blank_q ? '0 : rd_q;
    assign out_hsync_n = hs_out_q;
    assign out_vsync_n = vs_out_q;
    assign line_valid  = line_valid_q;
endmodule

// File: tb/tb_vga_scan_doubler.sv
// tb_vga_scan_doubler: line table plus random lines checked against a pixel-level model of the doubler.
module tb_vga_scan_doubler;
    localparam int MAXP = 511;

    typedef struct {
        int   len;
        int   hsw;
        logic vs_n;
        logic ramp;
        logic exp_valid;
    } rec_t;

    logic       clk = 1'b0, nRESET = 1'b1, ce_pix = 1'b0, ce_pix2x = 1'b0;
    logic       in_hsync_n = 1'b1, in_vsync_n = 1'b1, scanline_on = 1'b0;
    logic [3:0] in_rgb = 4'h0;
    logic [3:0] out_rgb;
    logic       out_hsync_n, out_vsync_n, line_valid;

    always #5 clk = ~clk;

    vga_scan_doubler dut (
        .clk(clk), .nRESET(nRESET), .ce_pix(ce_pix), .ce_pix2x(ce_pix2x),
        .in_rgb(in_rgb), .in_hsync_n(in_hsync_n), .in_vsync_n(in_vsync_n),
        .scanline_on(scanline_on), .out_rgb(out_rgb), .out_hsync_n(out_hsync_n),
        .out_vsync_n(out_vsync_n), .line_valid(line_valid)
    );

    int total = 0, bad = 0;
    int n, low_cnt, hs_meas, hs_len, disp_len, starts, j;
    int hs_run = 0, last_hs_run = 0, vs_lo = 0;
    logic count_vs = 1'b0;
    logic m_prev_hs, vs_latch, m_valid, e_hs, e_vs;
    logic [3:0] e_rgb;
    logic [3:0] cur_line [512];
    logic [3:0] disp_line [512];
    rec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        n = 1; low_cnt = 0; hs_meas = 0; hs_len = 0; disp_len = 0; starts = 0; j = 0;
        m_prev_hs = 1'b1; vs_latch = 1'b1; m_valid = 1'b0;
        e_hs = 1'b1; e_vs = 1'b1; e_rgb = 4'h0;
    endtask

    // one clk: predict outputs from the state before the edge, then advance the model
    task automatic step(input logic cp, input logic cp2, input logic [3:0] rgb, input logic hs, input logic vs);
        int pos, rep;
        logic start, blank;
        @(negedge clk);
        ce_pix = cp; ce_pix2x = cp2; scanline_on = 1'($urandom_range(0, 1));
        if (cp) begin
            in_rgb = rgb; in_hsync_n = hs; in_vsync_n = vs;
        end
        start = cp && m_prev_hs && !hs;
        if (cp2) begin
            pos = (disp_len == 0) ? 0 : j % disp_len;
            rep = (disp_len == 0) ? 0 : (j / disp_len) % 2;
            e_hs = (pos >= hs_len);
            blank = !e_hs || !m_valid;
`ifdef SCANLINES_EN
            blank = blank || (scanline_on && rep == 1);
`endif
            e_rgb = blank ? 4'h0 : disp_line[pos];
            if (pos == 0 && rep == 0) e_vs = vs_latch;
        end
        if (cp) begin
            if (start) begin
                disp_len = (n > MAXP) ? MAXP : n;
                hs_len = hs_meas;
                disp_line = cur_line;
                vs_latch = vs;
                starts++;
                if (starts >= 2) m_valid = 1'b1;
                n = 1; low_cnt = 1;
            end else begin
                n++;
                if (!hs) low_cnt++;
                if (!m_prev_hs && hs) hs_meas = (low_cnt > MAXP) ? MAXP : low_cnt;
            end
            if (n - 1 < MAXP) cur_line[n-1] = rgb;
            m_prev_hs = hs;
        end
        j = start ? 0 : cp2 ? j + 1 : j;
        @(posedge clk);
        #1;
        if (cp2) begin
            check("out", 32'({out_rgb, out_hsync_n, out_vsync_n, line_valid}), 32'({e_rgb, e_hs, e_vs, m_valid}));
            if (!out_hsync_n) hs_run++;
            else if (hs_run != 0) begin
                last_hs_run = hs_run; hs_run = 0;
            end
            if (count_vs && !out_vsync_n) vs_lo++;
        end
    endtask

    task automatic pixel(input logic [3:0] rgb, input logic hs, input logic vs);
        step(1'b1, 1'b1, rgb, hs, vs);
        step(1'b0, 1'b0, rgb, hs, vs);
        step(1'b0, 1'b1, rgb, hs, vs);
        step(1'b0, 1'b0, rgb, hs, vs);
    endtask

    task automatic send_line(input int len, input int hsw, input logic vs, input logic ramp);
        logic [3:0] r;
        for (int p = 0; p < len; p++) begin
            r = ramp ? p[3:0] : 4'($urandom);
            pixel(r, (p < hsw) ? 1'b0 : 1'b1, vs);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'(out_rgb), 32'h0);
        check({tag, "_hs"}, 32'(out_hsync_n), 32'h1);
        check({tag, "_vs"}, 32'(out_vsync_n), 32'h1);
        check({tag, "_valid"}, 32'(line_valid), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = '{384, 32, 1'b1, 1'b1, (i != 0)};
        tbl[4] = '{600, 32, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{384, 32, 1'b1, 1'b1, 1'b1};
        for (int i = 6; i < 16; i++) tbl[i] = '{100, 8, (i < 7 || i > 14), 1'b0, 1'b1};
        tbl[16] = '{50, 8, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{100, 8, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{100, 8, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 512; i++) cur_line[i] = 4'h0;

        #2 nRESET = 1'b0;
        #3 check_reset_outputs("reset");
        model_reset();
        @(negedge clk) nRESET = 1'b1;

        send_line(10, 0, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) begin
            if (i == 3) check("hs_width", 32'(last_hs_run), 32'd32);
            if (i == 6) begin
                vs_lo = 0; count_vs = 1'b1;
            end
            if (i == 16) begin
                count_vs = 1'b0;
                check("vs_low_len", 32'(vs_lo), 32'd1600);
            end
            send_line(tbl[i].len, tbl[i].hsw, tbl[i].vs_n, tbl[i].ramp);
            check("valid_rec", 32'(line_valid), 32'(tbl[i].exp_valid));
        end

        for (int i = 0; i < 12; i++) begin
            send_line($urandom_range(40, 150), $urandom_range(4, 20), ($urandom_range(0, 3) != 0), 1'b0);
            check("valid_rand", 32'(line_valid), 32'h1);
        end

        send_line(40, 32, 1'b1, 1'b1);
        @(negedge clk);
        ce_pix = 1'b0; ce_pix2x = 1'b0; nRESET = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        send_line(20, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_line(80, 10, 1'b1, 1'b0);
            check("valid_post", 32'(line_valid), 32'(i != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
